// File: rtl/pll_lock_ctrl.sv
// Reset/lock sequencer for a Gowin rPLL with dynamic divider selects.
// It runs the reset/lock/qualify cycle with retries, relocks after loss and handles reconfiguration.
module pll_lock_ctrl #(
    parameter int              SEL_W         = 6,
    parameter int              RST_CYCLES    = 16,
    parameter int              LOCK_TIMEOUT  = 65536,
    parameter int              STABLE_CYCLES = 1024,
    parameter int              MAX_RETRY     = 3,
    parameter bit              INVERT_SEL    = 1'b1,
    parameter logic [SEL_W-1:0] INIT_IDIV    = '0,
    parameter logic [SEL_W-1:0] INIT_FBDIV   = '0,
    parameter logic [SEL_W-1:0] INIT_ODIV    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idiv,
    input  logic [SEL_W-1:0] cfg_fbdiv,
    input  logic [SEL_W-1:0] cfg_odiv,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             locked,
    output logic             domain_rst,
    output logic             fail,
    output logic [7:0]       relock_cnt
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RTY_W     = $clog2(MAX_RETRY + 1);
    localparam logic [SEL_W-1:0] SEL_MASK = INVERT_SEL ? {SEL_W{1'b1}} : {SEL_W{1'b0}};

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [RTY_W-1:0]   retry_inc;
    logic [7:0]         relock_q, relock_d;
    logic [SEL_W-1:0]   idsel_q, idsel_d;
    logic [SEL_W-1:0]   fbdsel_q, fbdsel_d;
    logic [SEL_W-1:0]   odsel_q, odsel_d;
    logic               lock_meta_q, lock_s_q;
    logic               pll_reset_q, pll_reset_d;
    logic               locked_q, locked_d;
    logic               domain_rst_q, domain_rst_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               fail_q, fail_d;
    logic               accept;

    assign accept    = cfg_valid & cfg_ready_q;
    assign retry_inc = retry_q + RTY_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;

        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                // Any dropout restarts qualification from a fresh PLL reset.
                if (!lock_s_q) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_HOLD;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    retry_d = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // A reconfiguration takes precedence over a coincident lock loss.
                if (accept) begin
                    idsel_d  = cfg_idiv ^ SEL_MASK;
                    fbdsel_d = cfg_fbdiv ^ SEL_MASK;
                    odsel_d  = cfg_odiv ^ SEL_MASK;
                    cnt_d    = '0;
                    state_d  = ST_HOLD;
                end else if (!lock_s_q) begin
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_FAIL: begin
                if (accept) begin
                    idsel_d  = cfg_idiv ^ SEL_MASK;
                    fbdsel_d = cfg_fbdiv ^ SEL_MASK;
                    odsel_d  = cfg_odiv ^ SEL_MASK;
                    retry_d  = '0;
                    cnt_d    = '0;
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_HOLD;
            end
        endcase

        // Outputs are decoded from the next state so they switch on the same edge as the state.
        pll_reset_d  = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        locked_d     = (state_d == ST_RUN);
        domain_rst_d = (state_d != ST_RUN);
        cfg_ready_d  = (state_d == ST_RUN) || (state_d == ST_FAIL);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            relock_q     <= '0;
            idsel_q      <= INIT_IDIV ^ SEL_MASK;
            fbdsel_q     <= INIT_FBDIV ^ SEL_MASK;
            odsel_q      <= INIT_ODIV ^ SEL_MASK;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            domain_rst_q <= 1'b1;
            cfg_ready_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            idsel_q      <= idsel_d;
            fbdsel_q     <= fbdsel_d;
            odsel_q      <= odsel_d;
            lock_meta_q  <= pll_lock;
            lock_s_q     <= lock_meta_q;
            pll_reset_q  <= pll_reset_d;
            locked_q     <= locked_d;
            domain_rst_q <= domain_rst_d;
            cfg_ready_q  <= cfg_ready_d;
            fail_q       <= fail_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign domain_rst = domain_rst_q;
    assign fail       = fail_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: reset, lock, loss/relock, reconfiguration, timeouts and rst.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idiv, cfg_fbdiv, cfg_odiv;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       locked, domain_rst, fail;
    logic [7:0] relock_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_ctrl #(
        .SEL_W(6), .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8),
        .MAX_RETRY(2), .INVERT_SEL(1'b1),
        .INIT_IDIV(6'd3), .INIT_FBDIV(6'd0), .INIT_ODIV(6'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odiv(cfg_odiv),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .locked(locked), .domain_rst(domain_rst), .fail(fail), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-22s observed %0h expected %0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0;
        cfg_idiv = '0; cfg_fbdiv = '0; cfg_odiv = '0;
        tick(3);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_domain_rst", domain_rst, 1);
        check("rst_locked", locked, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_fail", fail, 0);
        check("rst_relock", relock_cnt, 0);
        check("rst_idsel", pll_idsel, 6'h3C);
        check("rst_fbdsel", pll_fbdsel, 6'h3F);
        check("rst_odsel", pll_odsel, 6'h3F);

        // Power-up lock
        rst = 1'b0;
        tick(3);
        check("hold_last_cycle", pll_reset, 1);
        tick(1);
        check("hold_released", pll_reset, 0);
        pll_lock = 1'b1;
        tick(10);
        check("lock_not_yet", locked, 0);
        tick(1);
        check("lock_locked", locked, 1);
        check("lock_domain_rst", domain_rst, 0);
        check("lock_cfg_ready", cfg_ready, 1);
        check("lock_relock", relock_cnt, 0);

        // Lock loss in RUN for 5 cycles, then automatic relock
        pll_lock = 1'b0;
        tick(2);
        check("loss_still_locked", locked, 1);
        tick(1);
        check("loss_locked", locked, 0);
        check("loss_domain_rst", domain_rst, 1);
        check("loss_pll_reset", pll_reset, 1);
        check("loss_relock", relock_cnt, 1);
        tick(2);
        pll_lock = 1'b1;
        tick(10);
        check("relock_not_yet", locked, 0);
        tick(1);
        check("relock_locked", locked, 1);

        // Request and lock loss on the same RUN cycle
        pll_lock = 1'b0;
        tick(2);
        check("simul_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_idiv = 6'd5; cfg_fbdiv = 6'd1; cfg_odiv = 6'd2;
        tick(1);
        cfg_valid = 1'b0;
        check("simul_idsel", pll_idsel, 6'h3A);
        check("simul_fbdsel", pll_fbdsel, 6'h3E);
        check("simul_odsel", pll_odsel, 6'h3D);
        check("simul_relock", relock_cnt, 1);
        check("simul_pll_reset", pll_reset, 1);
        check("simul_cfg_ready", cfg_ready, 0);

        // Request issued during WAIT_LOCK is held until RUN
        tick(4);
        check("wait_pll_reset", pll_reset, 0);
        cfg_valid = 1'b1; cfg_idiv = 6'd7; pll_lock = 1'b1;
        tick(1);
        check("wait_ready_low", cfg_ready, 0);
        check("wait_idsel_kept", pll_idsel, 6'h3A);
        tick(9);
        check("held_not_locked", locked, 0);
        check("held_idsel_kept", pll_idsel, 6'h3A);
        tick(1);
        check("held_run_locked", locked, 1);
        check("held_run_ready", cfg_ready, 1);
        tick(1);
        cfg_valid = 1'b0;
        check("held_idsel_new", pll_idsel, 6'h38);
        check("held_pll_reset", pll_reset, 1);
        check("held_locked", locked, 0);
        check("held_relock", relock_cnt, 1);

        // One-cycle lock glitch during STABLE
        tick(6);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        check("glitch_pre_reset", pll_reset, 0);
        tick(1);
        check("glitch_pll_reset", pll_reset, 1);
        check("glitch_retry", dut.retry_q, 1);
        check("glitch_fail", fail, 0);
        tick(12);
        check("glitch_not_locked", locked, 0);
        tick(1);
        check("glitch_locked", locked, 1);
        check("glitch_retry_clr", dut.retry_q, 0);

        // Two timeouts lead to FAIL
        pll_lock = 1'b0;
        tick(3);
        check("to_relock", relock_cnt, 2);
        check("to_locked", locked, 0);
        tick(4);
        check("to1_wait", pll_reset, 0);
        tick(31);
        check("to1_still_wait", pll_reset, 0);
        tick(1);
        check("to1_hold", pll_reset, 1);
        check("to1_fail", fail, 0);
        tick(4);
        check("to2_wait", pll_reset, 0);
        tick(31);
        check("to2_not_fail", fail, 0);
        tick(1);
        check("fail_fail", fail, 1);
        check("fail_cfg_ready", cfg_ready, 1);
        check("fail_pll_reset", pll_reset, 1);
        check("fail_domain_rst", domain_rst, 1);
        tick(5);
        check("fail_sticky", fail, 1);
        cfg_valid = 1'b1; cfg_idiv = 6'd5; cfg_fbdiv = 6'd0; cfg_odiv = 6'd0; pll_lock = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        check("recover_fail", fail, 0);
        check("recover_idsel", pll_idsel, 6'h3A);
        check("recover_fbdsel", pll_fbdsel, 6'h3F);
        check("recover_ready", cfg_ready, 0);
        tick(12);
        check("recover_not_locked", locked, 0);
        tick(1);
        check("recover_locked", locked, 1);

        // rst pulse during STABLE restores reset values
        cfg_valid = 1'b1; cfg_idiv = 6'd9;
        tick(1);
        cfg_valid = 1'b0;
        check("pre_rst_idsel", pll_idsel, 6'h36);
        tick(6);
        check("stable_pll_reset", pll_reset, 0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_pll_reset", pll_reset, 1);
        check("mid_rst_domain_rst", domain_rst, 1);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_cfg_ready", cfg_ready, 0);
        check("mid_rst_fail", fail, 0);
        check("mid_rst_relock", relock_cnt, 0);
        check("mid_rst_idsel", pll_idsel, 6'h3C);
        check("mid_rst_fbdsel", pll_fbdsel, 6'h3F);
        check("mid_rst_odsel", pll_odsel, 6'h3F);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
